// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and helpers for the Memoria arbiter slice.
//   state_e     - arbiter FSM states (IDLE, ISSUE, RWAIT)
//   requester_e - transaction owner (CPU port 0, DMA port 1)
//   cnt_width   - bits needed to hold the values 0..max
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RWAIT
   } state_e;

   typedef enum logic {
      REQ_CPU = 1'b0,
      REQ_DMA = 1'b1
   } requester_e;

   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: fixed-priority pick with DMA starvation override.
//   cpu_req   in   CPU request
//   dma_req   in   DMA request
//   wait_cnt  in   consecutive DMA losses so far
//   winner    out  requester to grant (CPU by default)
//   wait_next out  wait_cnt value to store if this pick is taken
module mem_arb_pick
   import mem_arb_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 4,
   parameter int unsigned CNT_W    = 3
)(
   input  logic             cpu_req,
   input  logic             dma_req,
   input  logic [CNT_W-1:0] wait_cnt,
   output requester_e       winner,
   output logic [CNT_W-1:0] wait_next
);

   logic starve;

   assign starve = (wait_cnt == CNT_W'(MAX_WAIT));

   always_comb begin
      winner    = REQ_CPU;
      wait_next = wait_cnt;
      if (dma_req && (!cpu_req || starve)) begin
         winner    = REQ_DMA;
         wait_next = '0;
      end else if (dma_req && cpu_req) begin
         // starve is false here, so the count is below MAX_WAIT and cannot overflow
         wait_next = wait_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port Memoria between the CPU path (port 0)
// and a DMA/loader master (port 1), one transaction at a time.
//   Clk, Reset                  clock, async active-high reset
//   cpu_req/wr/addr/wdata       CPU request (held until cpu_gnt)
//   cpu_gnt, cpu_rvalid         one-cycle grant / read-data-valid pulses
//   cpu_rdata                   last CPU read data
//   dma_*                       same set for the DMA port
//   mem_addr/mem_wr/mem_wdata   to Memoria
//   mem_rdata                   from Memoria, valid MEM_LAT cycles after address
//   busy                        high in ISSUE or RWAIT
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MEM_LAT  = 1,
   parameter int unsigned MAX_WAIT = 4
)(
   input  logic              Clk,
   input  logic              Reset,
   input  logic              cpu_req,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dma_req,
   input  logic              dma_wr,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_gnt,
   output logic              dma_rvalid,
   output logic [DATA_W-1:0] dma_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int unsigned CNT_W = cnt_width(MAX_WAIT);
   localparam int unsigned LAT_W = cnt_width(MEM_LAT);

   state_e           state, state_next;
   requester_e       owner;
   requester_e       winner;
   logic             lat_wr;
   logic [CNT_W-1:0] wait_cnt, wait_next;
   logic [LAT_W-1:0] lat_cnt;
   logic             arb;
   logic             capture;

   mem_arb_pick #(
      .MAX_WAIT (MAX_WAIT),
      .CNT_W    (CNT_W)
   ) u_pick (
      .cpu_req   (cpu_req),
      .dma_req   (dma_req),
      .wait_cnt  (wait_cnt),
      .winner    (winner),
      .wait_next (wait_next)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      arb        = 1'b0;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (cpu_req || dma_req) begin
               arb        = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (lat_wr) begin
               state_next = IDLE;
            end else if (MEM_LAT == 1) begin
               capture    = 1'b1;
               state_next = IDLE;
            end else begin
               state_next = RWAIT;
            end
         end
         RWAIT: begin
            if (lat_cnt == LAT_W'(1)) begin
               capture    = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Request latch: mem_addr/mem_wdata double as the latched request and hold
   // their value outside transactions.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         owner     <= REQ_CPU;
         lat_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         wait_cnt  <= '0;
      end else if (arb) begin
         owner    <= winner;
         wait_cnt <= wait_next;
         if (winner == REQ_DMA) begin
            lat_wr    <= dma_wr;
            mem_addr  <= dma_addr;
            mem_wdata <= dma_wdata;
         end else begin
            lat_wr    <= cpu_wr;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         lat_cnt <= '0;
      end else if (state == ISSUE) begin
         lat_cnt <= LAT_W'(MEM_LAT - 1);
      end else if (state == RWAIT) begin
         lat_cnt <= lat_cnt - LAT_W'(1);
      end
   end

   // Read return: rvalid is registered so it lands in the first IDLE cycle
   // after the capture edge; reset kills any read still in flight.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         cpu_rvalid <= 1'b0;
         dma_rvalid <= 1'b0;
         cpu_rdata  <= '0;
         dma_rdata  <= '0;
      end else begin
         cpu_rvalid <= 1'b0;
         dma_rvalid <= 1'b0;
         if (capture) begin
            if (owner == REQ_DMA) begin
               dma_rdata  <= mem_rdata;
               dma_rvalid <= 1'b1;
            end else begin
               cpu_rdata  <= mem_rdata;
               cpu_rvalid <= 1'b1;
            end
         end
      end
   end

   assign cpu_gnt = (state == ISSUE) && (owner == REQ_CPU);
   assign dma_gnt = (state == ISSUE) && (owner == REQ_DMA);
   assign mem_wr  = (state == ISSUE) && lat_wr;
   assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. Instance a uses MEM_LAT=3,
// instance b uses MEM_LAT=1; each has a memory model that returns valid data
// only exactly MEM_LAT-1 cycles after the issue cycle.
module tb_mem_arbiter;

   logic Clk = 1'b0;
   logic Reset;

   always #5 Clk = ~Clk;

   logic        a_cpu_req, a_cpu_wr, a_dma_req, a_dma_wr;
   logic [31:0] a_cpu_addr, a_cpu_wdata, a_dma_addr, a_dma_wdata;
   logic        a_cpu_gnt, a_cpu_rvalid, a_dma_gnt, a_dma_rvalid;
   logic [31:0] a_cpu_rdata, a_dma_rdata;
   logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
   logic        a_mem_wr, a_busy;

   logic        b_cpu_req, b_cpu_wr, b_dma_req, b_dma_wr;
   logic [31:0] b_cpu_addr, b_cpu_wdata, b_dma_addr, b_dma_wdata;
   logic        b_cpu_gnt, b_cpu_rvalid, b_dma_gnt, b_dma_rvalid;
   logic [31:0] b_cpu_rdata, b_dma_rdata;
   logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
   logic        b_mem_wr, b_busy;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .MAX_WAIT(4)) u_dut_a (
      .Clk(Clk), .Reset(Reset),
      .cpu_req(a_cpu_req), .cpu_wr(a_cpu_wr), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
      .cpu_gnt(a_cpu_gnt), .cpu_rvalid(a_cpu_rvalid), .cpu_rdata(a_cpu_rdata),
      .dma_req(a_dma_req), .dma_wr(a_dma_wr), .dma_addr(a_dma_addr), .dma_wdata(a_dma_wdata),
      .dma_gnt(a_dma_gnt), .dma_rvalid(a_dma_rvalid), .dma_rdata(a_dma_rdata),
      .mem_addr(a_mem_addr), .mem_wr(a_mem_wr), .mem_wdata(a_mem_wdata),
      .mem_rdata(a_mem_rdata), .busy(a_busy)
   );

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_WAIT(4)) u_dut_b (
      .Clk(Clk), .Reset(Reset),
      .cpu_req(b_cpu_req), .cpu_wr(b_cpu_wr), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
      .cpu_gnt(b_cpu_gnt), .cpu_rvalid(b_cpu_rvalid), .cpu_rdata(b_cpu_rdata),
      .dma_req(b_dma_req), .dma_wr(b_dma_wr), .dma_addr(b_dma_addr), .dma_wdata(b_dma_wdata),
      .dma_gnt(b_dma_gnt), .dma_rvalid(b_dma_rvalid), .dma_rdata(b_dma_rdata),
      .mem_addr(b_mem_addr), .mem_wr(b_mem_wr), .mem_wdata(b_mem_wdata),
      .mem_rdata(b_mem_rdata), .busy(b_busy)
   );

   // Memory models: contents preset to 0xA5000000 | index during reset.
   logic [31:0] mem_a [0:255];
   logic [31:0] mem_b [0:255];
   int unsigned age_a, age_b;

   always @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < 256; i++) begin
            mem_a[i] <= 32'hA500_0000 | i;
            mem_b[i] <= 32'hA500_0000 | i;
         end
         age_a <= 0;
         age_b <= 0;
      end else begin
         if (a_mem_wr) mem_a[a_mem_addr[7:0]] <= a_mem_wdata;
         if (b_mem_wr) mem_b[b_mem_addr[7:0]] <= b_mem_wdata;
         age_a <= (a_cpu_gnt || a_dma_gnt) ? 1 : age_a + 1;
         age_b <= (b_cpu_gnt || b_dma_gnt) ? 1 : age_b + 1;
      end
   end

   always_comb begin
      a_mem_rdata = 32'hBADB_AD00;
      b_mem_rdata = 32'hBADB_AD00;
      if (!(a_cpu_gnt || a_dma_gnt) && age_a == 2) a_mem_rdata = mem_a[a_mem_addr[7:0]];
      if (b_cpu_gnt || b_dma_gnt)                  b_mem_rdata = mem_b[b_mem_addr[7:0]];
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      logic       exp_g, exp_dma;
      int         g;
      logic [31:0] exp_addr;

      Reset = 1'b1;
      a_cpu_req = 0; a_cpu_wr = 0; a_cpu_addr = '0; a_cpu_wdata = '0;
      a_dma_req = 0; a_dma_wr = 0; a_dma_addr = '0; a_dma_wdata = '0;
      b_cpu_req = 0; b_cpu_wr = 0; b_cpu_addr = '0; b_cpu_wdata = '0;
      b_dma_req = 0; b_dma_wr = 0; b_dma_addr = '0; b_dma_wdata = '0;
      repeat (2) step();

      // Reset state
      check("rst_busy",   a_busy, 0);
      check("rst_mem_wr", a_mem_wr, 0);
      check("rst_gnt",    {a_cpu_gnt, a_dma_gnt}, 0);
      check("rst_rvalid", {a_cpu_rvalid, a_dma_rvalid}, 0);
      check("rst_maddr",  a_mem_addr, 0);
      check("rst_mwdata", a_mem_wdata, 0);
      check("rst_crdata", a_cpu_rdata, 0);
      check("rst_drdata", a_dma_rdata, 0);
      check("rst_b_busy", b_busy, 0);
      Reset = 1'b0;
      step();

      // CPU write 0x10 <= DEADBEEF, then read it back (MEM_LAT=3)
      a_cpu_req = 1; a_cpu_wr = 1; a_cpu_addr = 32'h10; a_cpu_wdata = 32'hDEAD_BEEF;
      check("wr_T_mem_wr", a_mem_wr, 0);
      step();
      check("wr_gnt",     a_cpu_gnt, 1);
      check("wr_dma_gnt", a_dma_gnt, 0);
      check("wr_mem_wr",  a_mem_wr, 1);
      check("wr_maddr",   a_mem_addr, 32'h10);
      check("wr_mwdata",  a_mem_wdata, 32'hDEAD_BEEF);
      check("wr_busy",    a_busy, 1);
      a_cpu_req = 0; a_cpu_wr = 0;
      step();
      check("wr_gnt_off",  a_cpu_gnt, 0);
      check("wr_mwr_off",  a_mem_wr, 0);
      check("wr_busy_off", a_busy, 0);
      check("wr_maddr_hold", a_mem_addr, 32'h10);
      a_cpu_req = 1; a_cpu_addr = 32'h10;
      step();
      check("rd_gnt",    a_cpu_gnt, 1);
      check("rd_mem_wr", a_mem_wr, 0);
      a_cpu_req = 0;
      for (int k = 2; k <= 3; k++) begin
         step();
         check("rd_wait_rvalid", a_cpu_rvalid, 0);
         check("rd_wait_busy",   a_busy, 1);
      end
      step();
      check("rd_rvalid",     a_cpu_rvalid, 1);
      check("rd_data",       a_cpu_rdata, 32'hDEAD_BEEF);
      check("rd_dma_rvalid", a_dma_rvalid, 0);
      check("rd_busy_off",   a_busy, 0);
      step();
      check("rd_rvalid_pulse", a_cpu_rvalid, 0);
      check("rd_data_hold",    a_cpu_rdata, 32'hDEAD_BEEF);

      // DMA read 0x20 with MEM_LAT=3
      a_dma_req = 1; a_dma_wr = 0; a_dma_addr = 32'h20;
      step();
      check("dma_gnt",     a_dma_gnt, 1);
      check("dma_cpu_gnt", a_cpu_gnt, 0);
      check("dma_maddr1",  a_mem_addr, 32'h20);
      a_dma_req = 0;
      for (int k = 2; k <= 3; k++) begin
         step();
         check("dma_maddr_held", a_mem_addr, 32'h20);
         check("dma_mem_wr",     a_mem_wr, 0);
         check("dma_early_rv",   a_dma_rvalid, 0);
      end
      step();
      check("dma_rvalid",  a_dma_rvalid, 1);
      check("dma_rdata",   a_dma_rdata, 32'hA500_0020);
      check("dma_cpu_rv",  a_cpu_rvalid, 0);
      check("dma_cpu_rd_keep", a_cpu_rdata, 32'hDEAD_BEEF);

      // Simultaneous reads: CPU first, DMA next
      a_cpu_req = 1; a_cpu_addr = 32'h30;
      a_dma_req = 1; a_dma_addr = 32'h40;
      step();
      check("tie_cpu_gnt", a_cpu_gnt, 1);
      check("tie_dma_gnt", a_dma_gnt, 0);
      a_cpu_req = 0;
      step(); step();
      check("tie_dma_wait", a_dma_gnt, 0);
      step();
      check("tie_cpu_rv",   a_cpu_rvalid, 1);
      check("tie_cpu_data", a_cpu_rdata, 32'hA500_0030);
      check("tie_dma_rv0",  a_dma_rvalid, 0);
      step();
      check("tie_dma_gnt2", a_dma_gnt, 1);
      check("tie_maddr2",   a_mem_addr, 32'h40);
      a_dma_req = 0;
      step(); step(); step();
      check("tie_dma_rv",    a_dma_rvalid, 1);
      check("tie_dma_data",  a_dma_rdata, 32'hA500_0040);
      check("tie_cpu_rv0",   a_cpu_rvalid, 0);
      check("tie_cpu_keep",  a_cpu_rdata, 32'hA500_0030);
      step();

      // Starvation + back-to-back writes: grants on odd cycles, DMA on the
      // 5th and 10th arbitrations.
      a_cpu_req = 1; a_cpu_wr = 1; a_cpu_addr = 32'h50; a_cpu_wdata = 32'h0000_0055;
      a_dma_req = 1; a_dma_wr = 1; a_dma_addr = 32'h60; a_dma_wdata = 32'h1111_2222;
      for (int cyc = 1; cyc <= 22; cyc++) begin
         step();
         exp_g   = (cyc % 2) == 1;
         g       = (cyc + 1) / 2;
         exp_dma = exp_g && (g == 5 || g == 10);
         check("b2b_gnt",    a_cpu_gnt | a_dma_gnt, exp_g);
         check("b2b_mem_wr", a_mem_wr, exp_g);
         check("b2b_busy",   a_busy, exp_g);
         if (exp_g) begin
            exp_addr = exp_dma ? ((g == 5) ? 32'h60 : 32'h61) : 32'h50;
            check("b2b_dma_gnt", a_dma_gnt, exp_dma);
            check("b2b_maddr",   a_mem_addr, exp_addr);
         end
         if (cyc == 9 || cyc == 19) a_dma_req = 0;
         if (cyc == 10) begin
            a_dma_req = 1; a_dma_addr = 32'h61; a_dma_wdata = 32'h3333_4444;
         end
         if (cyc == 21) a_cpu_req = 0;
      end
      step();
      check("b2b_idle",   a_busy, 0);
      check("b2b_mem60",  mem_a[8'h60], 32'h1111_2222);
      check("b2b_mem61",  mem_a[8'h61], 32'h3333_4444);
      check("b2b_mem50",  mem_a[8'h50], 32'h0000_0055);
      a_cpu_wr = 0; a_dma_wr = 0;

      // Reset while a read sits in RWAIT
      a_cpu_req = 1; a_cpu_addr = 32'h30;
      step();
      check("mrst_gnt", a_cpu_gnt, 1);
      a_cpu_req = 0;
      step();
      check("mrst_pre_busy", a_busy, 1);
      Reset = 1'b1;
      #1;
      check("mrst_busy",   a_busy, 0);
      check("mrst_gnt0",   {a_cpu_gnt, a_dma_gnt}, 0);
      check("mrst_mem_wr", a_mem_wr, 0);
      check("mrst_maddr",  a_mem_addr, 0);
      check("mrst_mwdata", a_mem_wdata, 0);
      check("mrst_crdata", a_cpu_rdata, 0);
      check("mrst_drdata", a_dma_rdata, 0);
      step();
      Reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         check("mrst_no_rvalid", {a_cpu_rvalid, a_dma_rvalid}, 0);
      end
      a_dma_req = 1; a_dma_addr = 32'h20;
      step();
      check("mrst_next_gnt", a_dma_gnt, 1);
      check("mrst_next_addr", a_mem_addr, 32'h20);
      a_dma_req = 0;
      step(); step(); step();
      check("mrst_next_rv",   a_dma_rvalid, 1);
      check("mrst_next_data", a_dma_rdata, 32'hA500_0020);

      // MEM_LAT=1 instance: write then read, then DMA read
      b_cpu_req = 1; b_cpu_wr = 1; b_cpu_addr = 32'h10; b_cpu_wdata = 32'hCAFE_F00D;
      step();
      check("l1_wr_gnt",   b_cpu_gnt, 1);
      check("l1_wr_memwr", b_mem_wr, 1);
      b_cpu_req = 0; b_cpu_wr = 0;
      step();
      check("l1_wr_busy0", b_busy, 0);
      b_cpu_req = 1;
      step();
      check("l1_rd_gnt",  b_cpu_gnt, 1);
      check("l1_rd_rv0",  b_cpu_rvalid, 0);
      b_cpu_req = 0;
      step();
      check("l1_rd_rv",    b_cpu_rvalid, 1);
      check("l1_rd_data",  b_cpu_rdata, 32'hCAFE_F00D);
      check("l1_rd_busy0", b_busy, 0);
      b_dma_req = 1; b_dma_addr = 32'h20;
      step();
      check("l1_rv_pulse", b_cpu_rvalid, 0);
      check("l1_dma_gnt",  b_dma_gnt, 1);
      b_dma_req = 0;
      step();
      check("l1_dma_rv",   b_dma_rvalid, 1);
      check("l1_dma_data", b_dma_rdata, 32'hA500_0020);
      check("l1_cpu_keep", b_cpu_rdata, 32'hCAFE_F00D);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port Memoria between two requesters: port 0 is the CPU load/store/fetch path (the address from the IouD selection), and port 1 is a DMA/program-loader master.
- Handles one transaction at a time with a registered request/grant handshake and fixed CPU priority.
- Contains a starvation counter that forces a DMA grant after MAX_WAIT consecutive losses.
- Sits between the CPU address/data muxes, the loader, and the Memoria instance.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, Memoria read latency in cycles (>=1): cycles from address presented to mem_rdata valid.
- MAX_WAIT, 4, consecutive DMA losses after which DMA wins the next arbitration (>=1).

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU requests a transaction.
- cpu_wr  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  one-cycle pulse: CPU request accepted and issued.
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid.
- cpu_rdata  out  DATA_W  CPU read data.
- dma_req, dma_wr, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata: same as the cpu_* ports, for the DMA port.
- mem_addr  out  ADDR_W  to Memoria Address.
- mem_wr  out  1  to Memoria Wr.
- mem_wdata  out  DATA_W  to Memoria DataIn.
- mem_rdata  in  DATA_W  from Memoria DataOut.
- busy  out  1  high while in ISSUE or RWAIT.

Behaviour:
- Reset (async):
  - state=IDLE.
  - All gnt/rvalid/mem_wr/busy = 0.
  - mem_addr, mem_wdata, cpu_rdata, dma_rdata = 0.
  - owner=CPU, wait_cnt=0, lat_cnt=0.
  - A read in flight is discarded; no rvalid is ever produced for it.
- States:
  - IDLE: req inputs are sampled only here.
    - No req: stay in IDLE.
    - Any req: latch the winner, its wr, addr and wdata; go to ISSUE.
  - ISSUE (exactly 1 cycle):
    - mem_addr/mem_wdata drive the latched values; winner gnt=1.
    - mem_wr = latched wr.
    - Write: go to IDLE.
    - Read with MEM_LAT=1: capture mem_rdata at the end of the cycle; go to IDLE.
    - Read with MEM_LAT>1: go to RWAIT with lat_cnt=MEM_LAT-1.
  - RWAIT:
    - mem_addr held, mem_wr=0; lat_cnt decrements each cycle.
    - On the cycle lat_cnt==1: capture mem_rdata; go to IDLE.
- Read return:
  - The captured data goes to the owner's rdata register.
  - The owner's rvalid pulses for 1 cycle, in the first IDLE cycle after the capture.
  - rdata holds until the owner's next read completes; the other port's rdata is unaffected.
- Latency (req first seen high in IDLE at cycle T):
  - gnt at T+1.
  - Write: mem_wr high only at T+1; the next arbitration can occur at T+2.
  - Read: rvalid at T+1+MEM_LAT.
- Arbitration:
  - CPU wins ties unless wait_cnt==MAX_WAIT.
  - wait_cnt increments when dma_req=1 and the CPU wins; it saturates at MAX_WAIT.
  - wait_cnt clears on a DMA grant.
  - wait_cnt is unchanged when dma_req=0.
- Handshake rules:
  - A requester holds req, wr, addr and wdata stable until it samples gnt=1.
  - req seen in non-IDLE states is ignored; the request stays pending.
  - A req still high when the arbiter is back in IDLE is a new transaction. A requester wanting only one transaction drops req at the edge where it samples gnt.
- Idle outputs:
  - mem_wr=0 outside ISSUE.
  - mem_addr/mem_wdata hold their last values.
- Simultaneous events: an rvalid pulse and a new arbitration (IDLE sampling) in the same cycle are legal.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, ISSUE, RWAIT}.
  - requester enum {REQ_CPU=0, REQ_DMA=1}.
- Sub-module mem_arb_pick:
  - Inputs: cpu_req, dma_req, wait_cnt==MAX_WAIT.
  - Outputs: winner, plus the wait_cnt next-value logic.
  - The top module holds the FSM, datapath latches and read-return registers.

Test Plan:
- Reset mid-read (MEM_LAT=3, Reset asserted during RWAIT):
  - All outputs 0 immediately.
  - No rvalid afterwards.
  - The next request gets gnt exactly 1 cycle after req.
- CPU write addr=0x10, wdata=0xDEADBEEF at T:
  - cpu_gnt=1 and mem_wr=1 with mem_addr=0x10 at T+1 only.
  - Then a CPU read of 0x10 returns cpu_rdata=0xDEADBEEF with cpu_rvalid 1+MEM_LAT cycles after its req.
- MEM_LAT=3, DMA read addr=0x20:
  - dma_gnt at T+1; mem_addr=0x20 held T+1..T+3.
  - dma_rvalid at T+4; cpu_rvalid stays 0.
- cpu_req and dma_req both high at T, both reads:
  - CPU granted at T+1 and DMA granted next.
  - Each rvalid appears only on its own port, with the correct data.
- MAX_WAIT=4, cpu_req held continuously, dma_req held:
  - CPU granted 4 times, then DMA granted on the 5th arbitration.
  - wait_cnt returns to 0, then the CPU is granted again.
- Back-to-back CPU writes with req held high:
  - Grants occur every 2 cycles.
  - mem_wr never high in consecutive cycles.
  - busy=1 only during ISSUE cycles.
